// File: rtl/draw_pkg.sv
// Shared constants, pixel/address types and FSM encoding for the blitter.
package draw_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int FB_ADDR_W  = 17;
  localparam int SRC_ADDR_W = 17;
  localparam int PIX_W      = 24;
  localparam int COORD_W    = 9;

  typedef logic [PIX_W-1:0]     pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/draw_blit_if.sv
// Command, ROM read and frame buffer write signals of the blitter.
interface draw_blit_if
  import draw_pkg::*;
#(
  parameter int SRC_W = SRC_ADDR_W,
  parameter int FB_W  = FB_ADDR_W,
  parameter int PIX   = PIX_W,
  parameter int CW    = COORD_W
);
  logic             start;
  logic [SRC_W-1:0] src_base;
  logic [CW-1:0]    dst_x;
  logic [CW-1:0]    dst_y;
  logic [CW-1:0]    blk_w;
  logic [CW-1:0]    blk_h;
  logic             key_en;
  logic [PIX-1:0]   key_color;
  logic             busy;
  logic             done;
  logic [SRC_W-1:0] rom_addr;
  logic [PIX-1:0]   rom_data;
  logic             frame_buf_we;
  logic [FB_W-1:0]  frame_buf_addr;
  logic [PIX-1:0]   frame_buf_data;

  modport slave (
    input  start, src_base, dst_x, dst_y, blk_w, blk_h, key_en, key_color, rom_data,
    output busy, done, rom_addr, frame_buf_we, frame_buf_addr, frame_buf_data
  );

  modport master (
    output start, src_base, dst_x, dst_y, blk_w, blk_h, key_en, key_color, rom_data,
    input  busy, done, rom_addr, frame_buf_we, frame_buf_addr, frame_buf_data
  );
endinterface

// File: rtl/draw_blit_delay.sv
// LAT-stage delay line carrying {valid, clip, fb_addr} alongside the ROM read.
module blit_delay #(
  parameter int LAT = 1,
  parameter int AW  = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_clip,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic          out_clip,
  output logic [AW-1:0] out_addr
);
  localparam int W = AW + 2;

  logic [W-1:0] pipe_reg [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= {in_valid, in_clip, in_addr};
      for (int i = 1; i < LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign {out_valid, out_clip, out_addr} = pipe_reg[LAT-1];
endmodule

// File: rtl/draw_blit.sv
// Rectangular block copy from source ROM to frame buffer, one pixel per cycle,
// with edge clipping and optional transparent colour key.
module draw_blit
  import draw_pkg::*;
#(
  parameter int SCREEN_W   = draw_pkg::SCREEN_W,
  parameter int SCREEN_H   = draw_pkg::SCREEN_H,
  parameter int FB_ADDR_W  = draw_pkg::FB_ADDR_W,
  parameter int SRC_ADDR_W = draw_pkg::SRC_ADDR_W,
  parameter int PIX_W      = draw_pkg::PIX_W,
  parameter int COORD_W    = draw_pkg::COORD_W,
  parameter int ROM_LAT    = 1
) (
  input logic        clk,
  input logic        rst,
  draw_blit_if.slave bus
);
  localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [FB_ADDR_W-1:0] SW_FB = FB_ADDR_W'(SCREEN_W);
  localparam logic [COORD_W:0]     SW_C  = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]     SH_C  = (COORD_W+1)'(SCREEN_H);

  logic [1:0]            state_reg;
  logic [COORD_W-1:0]    w_reg, h_reg, col_reg, row_reg, dst_x_reg;
  logic [COORD_W:0]      x_reg, y_reg;
  logic [FB_ADDR_W-1:0]  row_base_reg, fb_addr_reg;
  logic [SRC_ADDR_W-1:0] rom_addr_reg;
  logic                  key_en_reg;
  logic [PIX_W-1:0]      key_reg;
  logic                  iss_valid_reg, busy_reg, done_reg;
  logic [DW-1:0]         drain_reg;

  logic                  col_last, row_last, iss_clip;
  logic                  d_valid, d_clip;
  logic [FB_ADDR_W-1:0]  d_addr, row_base_next;

  assign col_last      = (col_reg == w_reg - COORD_W'(1));
  assign row_last      = (row_reg == h_reg - COORD_W'(1));
  // Screen coordinates carry one extra bit so off-screen positions never wrap.
  assign iss_clip      = (x_reg >= SW_C) || (y_reg >= SH_C);
  assign row_base_next = row_base_reg + SW_FB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      w_reg         <= '0;
      h_reg         <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      dst_x_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      row_base_reg  <= '0;
      fb_addr_reg   <= '0;
      rom_addr_reg  <= '0;
      key_en_reg    <= 1'b0;
      key_reg       <= '0;
      iss_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      drain_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.blk_w != '0 && bus.blk_h != '0) begin
              state_reg     <= ST_ISSUE;
              busy_reg      <= 1'b1;
              iss_valid_reg <= 1'b1;
              w_reg         <= bus.blk_w;
              h_reg         <= bus.blk_h;
              dst_x_reg     <= bus.dst_x;
              key_en_reg    <= bus.key_en;
              key_reg       <= bus.key_color;
              col_reg       <= '0;
              row_reg       <= '0;
              x_reg         <= {1'b0, bus.dst_x};
              y_reg         <= {1'b0, bus.dst_y};
              rom_addr_reg  <= bus.src_base;
              row_base_reg  <= FB_ADDR_W'(bus.dst_y) * SW_FB;
              fb_addr_reg   <= FB_ADDR_W'(bus.dst_y) * SW_FB + FB_ADDR_W'(bus.dst_x);
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (col_last && row_last) begin
            iss_valid_reg <= 1'b0;
            state_reg     <= ST_DRAIN;
            drain_reg     <= DW'(ROM_LAT - 1);
          end else begin
            rom_addr_reg <= rom_addr_reg + SRC_ADDR_W'(1);
            if (col_last) begin
              col_reg      <= '0;
              row_reg      <= row_reg + COORD_W'(1);
              x_reg        <= {1'b0, dst_x_reg};
              y_reg        <= y_reg + (COORD_W+1)'(1);
              row_base_reg <= row_base_next;
              fb_addr_reg  <= row_base_next + FB_ADDR_W'(dst_x_reg);
            end else begin
              col_reg     <= col_reg + COORD_W'(1);
              x_reg       <= x_reg + (COORD_W+1)'(1);
              fb_addr_reg <= fb_addr_reg + FB_ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_reg == '0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            drain_reg <= drain_reg - DW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  blit_delay #(.LAT(ROM_LAT), .AW(FB_ADDR_W)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iss_valid_reg),
    .in_clip   (iss_clip),
    .in_addr   (fb_addr_reg),
    .out_valid (d_valid),
    .out_clip  (d_clip),
    .out_addr  (d_addr)
  );

  // Write enable is combinational from the delay line, so reset kills it at once.
  assign bus.frame_buf_we   = d_valid & ~d_clip & ~(key_en_reg & (bus.rom_data == key_reg));
  assign bus.frame_buf_addr = d_addr;
  assign bus.frame_buf_data = bus.rom_data;
  assign bus.rom_addr       = rom_addr_reg;
  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
endmodule

// File: tb/tb_draw_blit.sv
// Self-checking bench for draw_blit: two instances (ROM_LAT=1 and 3) share
// the command inputs; a behavioural model predicts every frame buffer write.
module tb_draw_blit;
  import draw_pkg::*;

  typedef struct packed {
    logic [16:0] a;
    logic [23:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] src_base;
  logic [8:0]  dst_x, dst_y, blk_w, blk_h;
  logic        key_en;
  logic [23:0] key_color;
  logic        use3;

  logic [23:0] mem [0:131071];
  logic [23:0] rom1_q;
  logic [23:0] p3 [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  draw_blit_if bus1 ();
  draw_blit_if bus3 ();

  assign bus1.start = start;     assign bus3.start = start;
  assign bus1.src_base = src_base; assign bus3.src_base = src_base;
  assign bus1.dst_x = dst_x;     assign bus3.dst_x = dst_x;
  assign bus1.dst_y = dst_y;     assign bus3.dst_y = dst_y;
  assign bus1.blk_w = blk_w;     assign bus3.blk_w = blk_w;
  assign bus1.blk_h = blk_h;     assign bus3.blk_h = blk_h;
  assign bus1.key_en = key_en;   assign bus3.key_en = key_en;
  assign bus1.key_color = key_color; assign bus3.key_color = key_color;

  // Source ROMs with latency 1 and 3
  always @(posedge clk) rom1_q <= mem[bus1.rom_addr];
  always @(posedge clk) begin
    p3[0] <= mem[bus3.rom_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.rom_data = rom1_q;
  assign bus3.rom_data = p3[2];

  draw_blit #(.ROM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  draw_blit #(.ROM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic        o_we, o_busy, o_done;
  logic [16:0] o_fb_addr, o_rom_addr;
  logic [23:0] o_fb_data;
  assign o_we       = use3 ? bus3.frame_buf_we   : bus1.frame_buf_we;
  assign o_busy     = use3 ? bus3.busy           : bus1.busy;
  assign o_done     = use3 ? bus3.done           : bus1.done;
  assign o_fb_addr  = use3 ? bus3.frame_buf_addr : bus1.frame_buf_addr;
  assign o_fb_data  = use3 ? bus3.frame_buf_data : bus1.frame_buf_data;
  assign o_rom_addr = use3 ? bus3.rom_addr       : bus1.rom_addr;

  task automatic build_model(input logic [16:0] sb, input int dx, input int dy,
                             input int w, input int h, input logic ke,
                             input logic [23:0] kc, output wr_t q[$]);
    logic [16:0] sa;
    logic [23:0] pix;
    int x, y;
    q = {};
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        sa = 17'(int'(sb) + r * w + c);
        x = dx + c;
        y = dy + r;
        pix = mem[sa];
        if (x < 320 && y < 240 && !(ke && pix == kc))
          q.push_back('{a: 17'(y * 320 + x), d: pix});
      end
    end
  endtask

  task automatic run_blit(input string name, input logic [16:0] sb, input int dx,
                          input int dy, input int w, input int h, input logic ke,
                          input logic [23:0] kc, input logic sel3, input int busy_start_at);
    wr_t q[$];
    wr_t e;
    int n, lat, done_exp, cyc, nexp, nwr;
    bit got_done;
    use3 = sel3;
    lat = sel3 ? 3 : 1;
    build_model(sb, dx, dy, w, h, ke, kc, q);
    nexp = q.size();
    n = w * h;
    done_exp = (n == 0) ? 1 : n + lat + 1;
    @(posedge clk); #1;
    src_base = sb; dst_x = 9'(dx); dst_y = 9'(dy); blk_w = 9'(w); blk_h = 9'(h);
    key_en = ke; key_color = kc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got_done = 0; nwr = 0;
    while (!got_done && cyc <= done_exp + 16) begin
      @(negedge clk);
      if (n > 0 && cyc <= n) begin
        n_checks++;
        if (o_rom_addr !== 17'(int'(sb) + cyc - 1)) begin
          n_err++;
          $display("FAIL %s rom_addr cyc=%0d got=%0d exp=%0d", name, cyc, o_rom_addr, 17'(int'(sb) + cyc - 1));
        end
      end
      if (cyc < done_exp) begin
        n_checks++;
        if (o_busy !== 1'(n > 0)) begin
          n_err++;
          $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, o_busy, n > 0);
        end
      end
      if (o_we === 1'b1) begin
        nwr++;
        n_checks++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_write cyc=%0d addr=%0d", name, cyc, o_fb_addr);
        end else begin
          e = q.pop_front();
          if (o_fb_addr !== e.a || o_fb_data !== e.d) begin
            n_err++;
            $display("FAIL %s write cyc=%0d got=%0d/%h exp=%0d/%h", name, cyc, o_fb_addr, o_fb_data, e.a, e.d);
          end
        end
      end
      if (o_done === 1'b1) begin
        got_done = 1;
        n_checks++;
        if (cyc != done_exp) begin
          n_err++;
          $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, done_exp);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_at_done got=%b exp=0", name, o_busy);
        end
      end
      if (cyc == busy_start_at) begin
        src_base = sb ^ 17'h0AAAA; dst_x = 9'd0; dst_y = 9'd0;
        blk_w = 9'd3; blk_h = 9'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    n_checks++;
    if (!got_done) begin
      n_err++;
      $display("FAIL %s done_timeout got=none exp=cycle %0d", name, done_exp);
    end
    n_checks++;
    if (nwr != nexp) begin
      n_err++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, nwr, nexp);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (o_we !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_after got=we%b/done%b/busy%b exp=0/0/0", name, o_we, o_done, o_busy);
      end
    end
    $display("blit %s: lat=%0d size=%0dx%0d at (%0d,%0d) writes=%0d expected=%0d", name, lat, w, h, dx, dy, nwr, nexp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.frame_buf_we !== 1'b0 ||
        bus1.rom_addr !== 17'd0 || bus1.frame_buf_addr !== 17'd0 ||
        bus3.busy !== 1'b0 || bus3.frame_buf_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values got=busy%b done%b we%b rom%0d fb%0d exp=all zero",
               bus1.busy, bus1.done, bus1.frame_buf_we, bus1.rom_addr, bus1.frame_buf_addr);
    end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_small_block();
    run_blit("small_4x2", 17'd100, 10, 5, 4, 2, 1'b0, 24'h0, 1'b0, 0);
  endtask

  task automatic test_rom_lat3();
    run_blit("lat3_4x2", 17'd100, 10, 5, 4, 2, 1'b0, 24'h0, 1'b1, 0);
  endtask

  task automatic test_clipping();
    run_blit("clip_8x4", 17'd2000, 316, 238, 8, 4, 1'b0, 24'h0, 1'b0, 0);
    run_blit("clip_far", 17'd3000, 500, 500, 3, 2, 1'b0, 24'h0, 1'b1, 0);
  endtask

  task automatic test_transparency();
    mem[17'd403] = 24'hFF00FF;
    run_blit("key_on", 17'd400, 50, 60, 4, 1, 1'b1, 24'hFF00FF, 1'b0, 0);
    run_blit("key_off", 17'd400, 50, 60, 4, 1, 1'b0, 24'hFF00FF, 1'b0, 0);
  endtask

  task automatic test_zero_size();
    run_blit("zero_w", 17'd10, 5, 5, 0, 7, 1'b0, 24'h0, 1'b0, 0);
    run_blit("zero_h", 17'd10, 5, 5, 7, 0, 1'b0, 24'h0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_blit("busy_start", 17'd700, 30, 40, 6, 3, 1'b0, 24'h0, 1'b0, 3);
    run_blit("busy_start3", 17'd900, 30, 40, 6, 3, 1'b0, 24'h0, 1'b1, 5);
  endtask

  task automatic test_random();
    logic [16:0] sb;
    int w, h, dx, dy;
    logic ke;
    logic [23:0] kc;
    for (int i = 0; i < 8; i++) begin
      sb = 17'($urandom);
      w = $urandom_range(1, 20);
      h = $urandom_range(1, 12);
      dx = $urandom_range(0, 330);
      dy = $urandom_range(0, 250);
      ke = 1'($urandom);
      kc = mem[17'(int'(sb) + $urandom_range(0, w * h - 1))];
      run_blit("random", sb, dx, dy, w, h, ke, kc, 1'(i % 2), 0);
    end
  endtask

  task automatic test_reset_midop();
    use3 = 1'b0;
    @(posedge clk); #1;
    src_base = 17'd500; dst_x = 9'd20; dst_y = 9'd20; blk_w = 9'd16; blk_h = 9'd16;
    key_en = 1'b0; key_color = 24'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus1.frame_buf_we !== 1'b1 || bus1.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midop_active got=we%b busy%b exp=1/1", bus1.frame_buf_we, bus1.busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus1.frame_buf_we !== 1'b0 || bus3.frame_buf_we !== 1'b0 ||
        bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset got=we%b we3=%b busy%b done%b exp=0/0/0/0",
               bus1.frame_buf_we, bus3.frame_buf_we, bus1.busy, bus1.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (bus1.done !== 1'b0 || bus1.frame_buf_we !== 1'b0 || bus3.done !== 1'b0 || bus1.busy !== 1'b0) begin
        n_err++;
        $display("FAIL midop_quiet got=done%b we%b done3=%b busy%b exp=0", bus1.done,
                 bus1.frame_buf_we, bus3.done, bus1.busy);
      end
    end
    $display("reset mid-op: block aborted");
    run_blit("after_reset", 17'd500, 20, 20, 16, 16, 1'b0, 24'h0, 1'b0, 0);
  endtask

  task automatic test_full_screen();
    run_blit("full_screen", 17'd0, 0, 0, 320, 240, 1'b0, 24'h0, 1'b0, 0);
  endtask

  initial begin
    start = 1'b0; src_base = '0; dst_x = '0; dst_y = '0; blk_w = '0; blk_h = '0;
    key_en = 1'b0; key_color = '0; use3 = 1'b0; rst = 1'b1;
    for (int i = 0; i < 131072; i++) begin
      mem[i] = 24'($urandom);
      if (mem[i] == 24'hFF00FF) mem[i] = 24'h00FF00;
    end
    test_reset();
    test_small_block();
    test_rom_lat3();
    test_clipping();
    test_transparency();
    test_zero_size();
    test_back_to_back();
    test_random();
    test_reset_midop();
    test_full_screen();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/draw_blit.md
Name: draw_blit

Overview:
- Parametrised successor to the full-screen map loader.
- Copies a rectangular W x H block of pixels from a source ROM into the frame buffer at a programmable (dst_x, dst_y) origin, at one pixel per cycle.
- Supports a configurable ROM read latency, clipping at screen edges and an optional transparent colour key.
- Sits between the game/sprite controller and the frame buffer write port; the full-screen map draw is the special case src_base=0, dst=(0,0), size=SCREEN_W x SCREEN_H.

Parameters:
- SCREEN_W, 320, frame buffer width in pixels.
- SCREEN_H, 240, frame buffer height in pixels.
- FB_ADDR_W, 17, frame buffer address width.
- SRC_ADDR_W, 17, source ROM address width.
- PIX_W, 24, pixel width.
- COORD_W, 9, width of coordinate and size fields.
- ROM_LAT, 1, ROM read latency in cycles (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  SRC_ADDR_W  ROM address of block pixel (0,0)
- dst_x  in  COORD_W  destination column of block origin
- dst_y  in  COORD_W  destination row of block origin
- blk_w  in  COORD_W  block width in pixels
- blk_h  in  COORD_W  block height in pixels
- key_en  in  1  enable transparent colour key
- key_color  in  PIX_W  transparent colour value
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rom_addr  out  SRC_ADDR_W  source ROM address (registered)
- rom_data  in  PIX_W  ROM output, valid ROM_LAT cycles after rom_addr
- frame_buf_we  out  1  frame buffer write enable
- frame_buf_addr  out  FB_ADDR_W  frame buffer address
- frame_buf_data  out  PIX_W  frame buffer data

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE; busy=0, done=0, frame_buf_we=0, rom_addr=0, frame_buf_addr=0. frame_buf_data is a direct pass-through of rom_data and is not reset.
- Reset mid-operation: frame_buf_we drops immediately (asynchronously), the pipeline is flushed, the block returns to IDLE and no done pulse is issued.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with blk_w!=0 and blk_h!=0: latch all inputs, go to ISSUE, set busy=1.
  - start=1 with blk_w==0 or blk_h==0: done=1 in the next cycle, no writes, stay in IDLE.
- ISSUE:
  - One ROM address per cycle, in row-major order (col increments fastest).
  - rom_addr = src_base + row*blk_w + col, generated by an incrementing counter (no multiplier).
  - The destination address is tracked incrementally as (dst_y+row)*SCREEN_W + dst_x + col. A row base register advances by SCREEN_W at each row end.
  - After issuing col=blk_w-1, row=blk_h-1, go to DRAIN.
- Issue pipeline: every issued pixel pushes {valid, clip, fb_addr} into a ROM_LAT-deep delay line, aligned with rom_data.
  - clip=1 when dst_x+col >= SCREEN_W or dst_y+row >= SCREEN_H. Compute at COORD_W+1 bits; no wrap-around.
- Write stage: frame_buf_we = valid & ~clip & ~(key_en & rom_data==key_color). frame_buf_addr is the delayed fb_addr.
- Clipped and keyed pixels still consume a ROM slot, so total timing is independent of content.
- DRAIN: wait ROM_LAT cycles, then assert done for one cycle, deassert busy and go to IDLE.
- Timing:
  - start sampled at cycle 0; first rom_addr at cycle 1.
  - First write slot at cycle 1+ROM_LAT.
  - done at cycle blk_w*blk_h + ROM_LAT + 1.
- start while busy is ignored; no queueing.

Decomposition:
- Shared package draw_pkg: SCREEN_W, SCREEN_H, FB_ADDR_W, PIX_W, COORD_W constants; pixel_t; fb_addr_t; blit state encoding.
- One sub-module, blit_delay: parametrised ROM_LAT-stage shift register for {valid, clip, fb_addr}, async reset clears valid.

Test Plan:
- Full screen: src_base=0, dst=(0,0), 320x240, ROM_LAT=1 -> 76800 writes, addrs 0..76799 in order; done at cycle 76802; busy low afterwards.
- Small block: 4x2 at (10,5), src_base=100 -> rom_addr 100..107; writes at 1610..1613 then 1930..1933; done at cycle 10.
- Clipping: 8x4 at (316,238) -> 32 ROM reads, only 8 writes (cols 316..319, rows 238..239), e.g. first write at 76476; done at cycle 34.
- Transparency: key_en=1, key_color=24'hFF00FF, ROM word 3 = FF00FF in a 4x1 block -> 3 writes, slot 3 we=0; repeat with key_en=0 -> 4 writes.
- Zero size and reuse: blk_w=0 -> done pulse at cycle 1, no writes; start while busy -> ignored, no address change.
- Reset mid-op: assert rst during ISSUE of a 16x16 block -> we=0 in the same cycle, state IDLE, no done; a new start afterwards runs a clean full block.
- ROM_LAT=3 build: 4x2 block -> first write at cycle 4; done at cycle 12; addresses aligned with data.
